// File: rtl/demux8_1_reg.sv
// Registered 1-to-8 write demultiplexer: one word per handshake is staged, then
// written into one of eight output slots with a one-hot strobe and sticky written flags.
module demux8_1_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         sel,
  input  logic               hold,
  input  logic               clear,
  output logic [8*WIDTH-1:0] out_data,
  output logic [7:0]         out_en,
  output logic [7:0]         written,
  output logic               overwrite
);

  localparam int unsigned NSLOT = 8;
  localparam int unsigned SELW  = 3;

  logic             s_valid;
  logic [SELW-1:0]  s_sel;
  logic [WIDTH-1:0] s_data;
  logic             do_write;
  logic [NSLOT-1:0] wr_onehot;
  logic [WIDTH-1:0] slot_q [NSLOT];

  // Acceptance depends only on reset and stall, never on in_valid.
  always_comb begin
    in_ready = reset & ~hold;
  end

  // Decode the staged select into the write strobe.
  always_comb begin
    do_write  = s_valid & ~hold;
    wr_onehot = '0;
    if (do_write) begin
      wr_onehot = NSLOT'(1) << s_sel;
    end
    out_en    = wr_onehot;
    overwrite = do_write & written[s_sel];
  end

  // Stage register; a held word stays put until hold drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid <= 1'b0;
      s_sel   <= '0;
      s_data  <= '0;
    end else if (!hold) begin
      s_valid <= in_valid;
      if (in_valid) begin
        s_sel  <= sel;
        s_data <= in_data;
      end
    end
  end

  // Slot bank: only the strobed slot changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (wr_onehot[k]) begin
          slot_q[k] <= s_data;
        end
      end
    end
  end

  // Sticky flags; a write at the same edge as clear keeps its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (!hold) begin
      written <= (clear ? NSLOT'(0) : written) | wr_onehot;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NSLOT; k++) begin
      out_data[k*WIDTH +: WIDTH] = slot_q[k];
    end
  end

endmodule

// File: tb/tb_demux8_1_reg.sv
// Directed table-driven bench for demux8_1_reg plus a hand-written reset-abort sequence.
module tb_demux8_1_reg;

  localparam int unsigned WIDTH = 64;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         sel;
  logic               hold;
  logic               clear;
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         out_en;
  logic [7:0]         written;
  logic               overwrite;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic             v;
    logic [2:0]       sel;
    logic [WIDTH-1:0] d;
    logic             hold;
    logic             clr;
    logic [7:0]       en;
    logic             ow;
    logic             rdy;
    logic [7:0]       wr;
    logic             cs;
    logic [2:0]       sl;
    logic [WIDTH-1:0] sv;
  } vec_t;

  vec_t vq[$];

  demux8_1_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .hold      (hold),
    .clear     (clear),
    .out_data  (out_data),
    .out_en    (out_en),
    .written   (written),
    .overwrite (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slot(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic add(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] d,
                     input logic h, input logic c, input logic [7:0] en, input logic ow,
                     input logic rdy, input logic [7:0] wr, input logic cs,
                     input logic [2:0] sl, input logic [WIDTH-1:0] sv);
    vec_t t;
    t.v = v; t.sel = s; t.d = d; t.hold = h; t.clr = c;
    t.en = en; t.ow = ow; t.rdy = rdy; t.wr = wr; t.cs = cs; t.sl = sl; t.sv = sv;
    vq.push_back(t);
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    in_valid = vq[i].v;
    sel      = vq[i].sel;
    in_data  = vq[i].d;
    hold     = vq[i].hold;
    clear    = vq[i].clr;
    #1;
    check($sformatf("v%0d out_en", i), WIDTH'(out_en), WIDTH'(vq[i].en));
    check($sformatf("v%0d overwrite", i), WIDTH'(overwrite), WIDTH'(vq[i].ow));
    check($sformatf("v%0d in_ready", i), WIDTH'(in_ready), WIDTH'(vq[i].rdy));
    @(posedge clk);
    #1;
    check($sformatf("v%0d written", i), WIDTH'(written), WIDTH'(vq[i].wr));
    if (vq[i].cs) begin
      check($sformatf("v%0d slot%0d", i, vq[i].sl), slot(int'(vq[i].sl)), vq[i].sv);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    sel = '0;
    hold = 1'b0;
    clear = 1'b0;

    //     v  sel  data           h  c  en     ow rdy wr     cs sl   sv
    // single write to slot 5
    add(1, 3'd5, 64'hDEAD_BEEF, 0, 0, 8'h00, 0, 1, 8'h00, 0, 3'd0, 64'd0);
    add(0, 3'd0, 64'd0,         0, 0, 8'h20, 0, 1, 8'h20, 1, 3'd5, 64'hDEAD_BEEF);
    // clear flags, then eight back-to-back writes
    add(0, 3'd0, 64'd0,         0, 1, 8'h00, 0, 1, 8'h00, 0, 3'd0, 64'd0);
    add(1, 3'd0, 64'd1,         0, 0, 8'h00, 0, 1, 8'h00, 0, 3'd0, 64'd0);
    add(1, 3'd1, 64'd2,         0, 0, 8'h01, 0, 1, 8'h01, 1, 3'd0, 64'd1);
    add(1, 3'd2, 64'd3,         0, 0, 8'h02, 0, 1, 8'h03, 1, 3'd1, 64'd2);
    add(1, 3'd3, 64'd4,         0, 0, 8'h04, 0, 1, 8'h07, 1, 3'd2, 64'd3);
    add(1, 3'd4, 64'd5,         0, 0, 8'h08, 0, 1, 8'h0F, 1, 3'd3, 64'd4);
    add(1, 3'd5, 64'd6,         0, 0, 8'h10, 0, 1, 8'h1F, 1, 3'd4, 64'd5);
    add(1, 3'd6, 64'd7,         0, 0, 8'h20, 0, 1, 8'h3F, 1, 3'd5, 64'd6);
    add(1, 3'd7, 64'd8,         0, 0, 8'h40, 0, 1, 8'h7F, 1, 3'd6, 64'd7);
    add(0, 3'd0, 64'd0,         0, 0, 8'h80, 0, 1, 8'hFF, 1, 3'd7, 64'd8);
    // write slot 2 then stall three cycles; offered word during hold is ignored
    add(1, 3'd2, 64'd7,         0, 0, 8'h00, 0, 1, 8'hFF, 0, 3'd0, 64'd0);
    add(1, 3'd0, 64'h99,        1, 0, 8'h00, 0, 0, 8'hFF, 1, 3'd2, 64'd3);
    add(1, 3'd0, 64'h99,        1, 0, 8'h00, 0, 0, 8'hFF, 1, 3'd2, 64'd3);
    add(1, 3'd0, 64'h99,        1, 1, 8'h00, 0, 0, 8'hFF, 1, 3'd2, 64'd3);
    add(0, 3'd0, 64'd0,         0, 0, 8'h04, 1, 1, 8'hFF, 1, 3'd2, 64'd7);
    add(0, 3'd0, 64'd0,         0, 0, 8'h00, 0, 1, 8'hFF, 1, 3'd0, 64'd1);
    // overwrite of slot 3 with clear at the write edge
    add(1, 3'd3, 64'd9,         0, 0, 8'h00, 0, 1, 8'hFF, 0, 3'd0, 64'd0);
    add(0, 3'd0, 64'd0,         0, 1, 8'h08, 1, 1, 8'h08, 1, 3'd3, 64'd9);
    add(0, 3'd0, 64'd0,         0, 0, 8'h00, 0, 1, 8'h08, 1, 3'd3, 64'd9);

    // reset release, idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst out_en", WIDTH'(out_en), WIDTH'(8'h00));
    check("rst in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    @(posedge clk);
    #1;
    check("rst written", WIDTH'(written), WIDTH'(8'h00));
    check("rst out_data zero", WIDTH'(out_data == '0), WIDTH'(1'b1));

    for (int i = 0; i < 2; i++) apply(i);
    for (int k = 0; k < 8; k++) begin
      if (k != 5) check($sformatf("untouched slot%0d", k), slot(k), 64'd0);
    end
    for (int i = 2; i < vq.size(); i++) apply(i);

    // accepted word dropped by reset before its write edge
    @(negedge clk);
    in_valid = 1'b1;
    sel = 3'd6;
    in_data = 64'h66;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort out_en in reset", WIDTH'(out_en), WIDTH'(8'h00));
    check("abort in_ready in reset", WIDTH'(in_ready), WIDTH'(1'b0));
    check("abort overwrite in reset", WIDTH'(overwrite), WIDTH'(1'b0));
    check("abort written in reset", WIDTH'(written), WIDTH'(8'h00));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort out_en after release", WIDTH'(out_en), WIDTH'(8'h00));
    @(posedge clk);
    #1;
    check("abort slot6", slot(6), 64'd0);
    check("abort written", WIDTH'(written), WIDTH'(8'h00));
    check("abort out_data zero", WIDTH'(out_data == '0), WIDTH'(1'b1));
    @(negedge clk);
    check("abort no late strobe", WIDTH'(out_en), WIDTH'(8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
